// File: rtl/uart_debug_pkg.sv
// Shared constants and types for the UART debug monitor: register map,
// control bit positions, line-status error bit positions and the snapshot layout.
package uart_debug_pkg;

    localparam int DBG_STAT0 = 'h08;
    localparam int DBG_STAT1 = 'h0C;
    localparam int DBG_WM    = 'h10;
    localparam int DBG_EVT   = 'h14;
    localparam int DBG_CTRL  = 'h18;

    localparam int CTRL_FREEZE  = 0;
    localparam int CTRL_ARM     = 1;
    localparam int CTRL_TRIG    = 2;
    localparam int CTRL_CLR_EVT = 4;
    localparam int CTRL_CLR_WM  = 5;

    localparam int LSR_OE = 1;
    localparam int LSR_PE = 2;
    localparam int LSR_FE = 3;
    localparam int LSR_BI = 4;

    // Index of each error event counter; also its byte lane in the event register.
    typedef enum logic [1:0] {
        EVT_OE = 2'd0,
        EVT_PE = 2'd1,
        EVT_FE = 2'd2,
        EVT_BI = 2'd3
    } evt_e;

    // Fixed-width UART register values captured by the snapshot.
    typedef struct packed {
        logic [7:0] msr;
        logic [7:0] lcr;
        logic [3:0] iir;
        logic [3:0] ier;
        logic [7:0] lsr;
        logic [1:0] fcr;
        logic [4:0] mcr;
        logic [3:0] rstate;
        logic [2:0] tstate;
    } uart_regs_t;

    function automatic logic [31:0] pack_stat0(input uart_regs_t r);
        return {r.msr, r.lcr, r.iir, r.ier, r.lsr};
    endfunction

endpackage

// File: rtl/uart_debug_sat_cnt.sv
// Saturating event counter: counts inc pulses up to all-ones and sticks there;
// clr takes priority over a simultaneous increment.
module uart_debug_sat_cnt #(
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [EVT_W-1:0] count
);

    localparam logic [EVT_W-1:0] CNT_MAX = '1;

    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_debug_monitor.sv
// Debug/observation block beside the UART register file: frozen or live register
// snapshots, FIFO high-watermarks and line-error counters over a Wishbone slave.
module uart_debug_monitor
    import uart_debug_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 5,
    parameter int EVT_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [3:0]        ier,
    input  logic [3:0]        iir,
    input  logic [1:0]        fcr,
    input  logic [4:0]        mcr,
    input  logic [7:0]        lcr,
    input  logic [7:0]        msr,
    input  logic [7:0]        lsr,
    input  logic [CNT_W-1:0]  rf_count,
    input  logic [CNT_W-1:0]  tf_count,
    input  logic [2:0]        tstate,
    input  logic [3:0]        rstate,
    output logic              frozen_o
);

    localparam logic [ADDR_W-1:0] ADR_STAT0 = ADDR_W'(DBG_STAT0);
    localparam logic [ADDR_W-1:0] ADR_STAT1 = ADDR_W'(DBG_STAT1);
    localparam logic [ADDR_W-1:0] ADR_WM    = ADDR_W'(DBG_WM);
    localparam logic [ADDR_W-1:0] ADR_EVT   = ADDR_W'(DBG_EVT);
    localparam logic [ADDR_W-1:0] ADR_CTRL  = ADDR_W'(DBG_CTRL);

    logic              access;
    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic              req_freeze;
    logic              req_arm;
    logic              req_clr_evt;
    logic              req_clr_wm;
    logic              ctrl_wr;
    logic              clr_evt;
    logic              clr_wm;
    logic [31:0]       rd_data;
    logic              unused_dat;

    logic              freeze;
    logic              arm;
    logic              triggered;
    logic              trig;

    uart_regs_t        live;
    uart_regs_t        snap;
    logic [CNT_W-1:0]  snap_rf;
    logic [CNT_W-1:0]  snap_tf;
    logic [CNT_W-1:0]  rf_max;
    logic [CNT_W-1:0]  tf_max;

    logic [3:0]        err_now;
    logic [3:0]        err_q;
    logic [3:0]        err_rise;
    logic [EVT_W-1:0]  evt_cnt [4];

    // ------------------------------------------------------------------
    // Wishbone front end: accept, ack one cycle later, commit writes on ack.
    // ------------------------------------------------------------------
    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign unused_dat = ^{wb_dat_i[31:6], wb_dat_i[3:2]};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            req_we      <= 1'b0;
            req_adr     <= '0;
            req_freeze  <= 1'b0;
            req_arm     <= 1'b0;
            req_clr_evt <= 1'b0;
            req_clr_wm  <= 1'b0;
        end else begin
            wb_ack_o <= access;
            if (access) begin
                wb_dat_o    <= rd_data;
                req_we      <= wb_we_i;
                req_adr     <= wb_adr_i;
                req_freeze  <= wb_dat_i[CTRL_FREEZE];
                req_arm     <= wb_dat_i[CTRL_ARM];
                req_clr_evt <= wb_dat_i[CTRL_CLR_EVT];
                req_clr_wm  <= wb_dat_i[CTRL_CLR_WM];
            end
        end
    end

    // The write lands on the edge that closes the ack cycle.
    assign ctrl_wr = wb_ack_o & req_we & (req_adr == ADR_CTRL);
    assign clr_evt = ctrl_wr & req_clr_evt;
    assign clr_wm  = ctrl_wr & req_clr_wm;

    // ------------------------------------------------------------------
    // Line-error edge detection and event counters
    // ------------------------------------------------------------------
    assign err_now  = {lsr[LSR_BI], lsr[LSR_FE], lsr[LSR_PE], lsr[LSR_OE]};
    assign err_rise = err_now & ~err_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_now;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_evt
        uart_debug_sat_cnt #(
            .EVT_W (EVT_W)
        ) u_cnt (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_i),
            .inc   (err_rise[i]),
            .clr   (clr_evt),
            .count (evt_cnt[i])
        );
    end

    // ------------------------------------------------------------------
    // Control: freeze / arm / triggered. A bus write outranks the trigger.
    // ------------------------------------------------------------------
    assign trig     = arm & ~freeze & (|err_rise) & ~ctrl_wr;
    assign frozen_o = freeze;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            freeze    <= 1'b0;
            arm       <= 1'b0;
            triggered <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= req_freeze;
            arm    <= req_arm;
            if (!req_freeze) begin
                triggered <= 1'b0;
            end
        end else if (trig) begin
            freeze    <= 1'b1;
            triggered <= 1'b1;
            arm       <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: tracks the live inputs until frozen. On a trigger freeze is
    // still 0 during cycle N, so the cycle-N values are what get held.
    // ------------------------------------------------------------------
    always_comb begin
        live        = '0;
        live.msr    = msr;
        live.lcr    = lcr;
        live.iir    = iir;
        live.ier    = ier;
        live.lsr    = lsr;
        live.fcr    = fcr;
        live.mcr    = mcr;
        live.rstate = rstate;
        live.tstate = tstate;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            snap    <= '0;
            snap_rf <= '0;
            snap_tf <= '0;
        end else if (!freeze) begin
            snap    <= live;
            snap_rf <= rf_count;
            snap_tf <= tf_count;
        end
    end

    // ------------------------------------------------------------------
    // FIFO high-watermarks (unsigned), clear outranks an update
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            rf_max <= '0;
            tf_max <= '0;
        end else if (clr_wm) begin
            rf_max <= '0;
            tf_max <= '0;
        end else begin
            if (rf_count > rf_max) begin
                rf_max <= rf_count;
            end
            if (tf_count > tf_max) begin
                tf_max <= tf_count;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, sampled into wb_dat_o at the acceptance edge
    // ------------------------------------------------------------------
    // NOTE: default first so no path leaves rd_data unassigned (no latch).
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_STAT0: rd_data = pack_stat0(snap);
            ADR_STAT1: rd_data = {8'h00, snap.fcr, snap.mcr, 5'(snap_rf),
                                  snap.rstate, 5'(snap_tf), snap.tstate};
            ADR_WM:    rd_data = {16'(tf_max), 16'(rf_max)};
            ADR_EVT:   rd_data = {8'(evt_cnt[EVT_BI]), 8'(evt_cnt[EVT_FE]),
                                  8'(evt_cnt[EVT_PE]), 8'(evt_cnt[EVT_OE])};
            ADR_CTRL:  rd_data = {26'd0, 3'b000, triggered, arm, freeze};
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_debug_monitor.sv
// Directed bench for uart_debug_monitor: register reads, freeze/trigger,
// watermarks, saturating counters, bus handshake and reset behaviour.
module tb_uart_debug_monitor;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 5;
    localparam int EVT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_w;
    logic [31:0]       dat_r;
    logic              ack;
    logic [3:0]        ier, iir;
    logic [1:0]        fcr;
    logic [4:0]        mcr;
    logic [7:0]        lcr, msr, lsr;
    logic [CNT_W-1:0]  rf_count, tf_count;
    logic [2:0]        tstate;
    logic [3:0]        rstate;
    logic              frozen;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_debug_monitor #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .EVT_W  (EVT_W)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .ier      (ier),
        .iir      (iir),
        .fcr      (fcr),
        .mcr      (mcr),
        .lcr      (lcr),
        .msr      (msr),
        .lsr      (lsr),
        .rf_count (rf_count),
        .tf_count (tf_count),
        .tstate   (tstate),
        .rstate   (rstate),
        .frozen_o (frozen)
    );

    // One access: strobe at a negedge, accepted at the next posedge,
    // ack/data sampled at the following negedge, then the strobe is dropped.
    task automatic bus(input logic we_v, input logic [ADDR_W-1:0] adr_v,
                       input logic [31:0] dat_v,
                       output logic [31:0] rd, output logic ak);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; dat_w = dat_v;
        @(negedge clk);
        ak = ack;
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ak;
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        ier = '0; iir = '0; fcr = '0; mcr = '0; lcr = '0; msr = '0; lsr = '0;
        rf_count = '0; tf_count = '0; tstate = '0; rstate = '0;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (dat_r !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_r); end
        checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
        rst_n = 1'b1;
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_wm got=%h exp=0", rd); end
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_evt got=%h exp=0", rd); end
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    endtask

    task automatic test_stat_read();
        logic [31:0] rd;
        logic ak;
        @(negedge clk);
        ier = 4'hA; lsr = 8'h60; lcr = 8'h03;
        @(negedge clk);
        bus(1'b0, 5'h08, 32'h0, rd, ak);
        checks++; if (ak !== 1'b1) begin failures++; $display("FAIL stat0_ack got=%b exp=1", ak); end
        checks++; if (rd !== 32'h0003_0A60) begin failures++; $display("FAIL stat0 got=%h exp=00030a60", rd); end
        fcr = 2'b10; mcr = 5'h15; rf_count = 5'd7; rstate = 4'h9; tf_count = 5'd17; tstate = 3'd6;
        @(negedge clk);
        bus(1'b0, 5'h0C, 32'h0, rd, ak);
        checks++; if (rd !== 32'h00AA_798E) begin failures++; $display("FAIL stat1 got=%h exp=00aa798e", rd); end
    endtask

    task automatic test_freeze();
        logic [31:0] rd;
        logic ak;
        bus(1'b1, 5'h18, 32'h1, rd, ak);
        @(negedge clk);
        lcr = 8'h83;
        checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL freeze_on got=%b exp=1", frozen); end
        bus(1'b0, 5'h08, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0003_0A60) begin failures++; $display("FAIL freeze_hold got=%h exp=00030a60", rd); end
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL freeze_ctrl got=%h exp=1", rd); end
        bus(1'b1, 5'h18, 32'h0, rd, ak);
        @(negedge clk);
        checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL freeze_off got=%b exp=0", frozen); end
        bus(1'b0, 5'h08, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0083_0A60) begin failures++; $display("FAIL unfreeze_live got=%h exp=00830a60", rd); end
    endtask

    task automatic test_watermark();
        logic [31:0] rd;
        logic ak;
        logic [4:0] ramp [6] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd9, 5'd3};
        @(negedge clk);
        tf_count = 5'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rf_count = ramp[i];
        end
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0011_000C) begin failures++; $display("FAIL wm_ramp got=%h exp=0011000c", rd); end
        @(negedge clk); rf_count = 5'd20;
        @(negedge clk); rf_count = 5'd3;
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0011_0014) begin failures++; $display("FAIL wm_unsigned got=%h exp=00110014", rd); end
        @(negedge clk); tf_count = 5'd31;
        @(negedge clk); tf_count = 5'd0; rf_count = 5'd0;
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h001F_0014) begin failures++; $display("FAIL wm_tf_max got=%h exp=001f0014", rd); end
        bus(1'b1, 5'h18, 32'h20, rd, ak);
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wm_clear got=%h exp=0", rd); end
    endtask

    task automatic test_evt_saturate();
        logic [31:0] rd;
        logic ak;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); lsr = 8'h62;
            @(negedge clk); lsr = 8'h60;
        end
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0000_00FF) begin failures++; $display("FAIL evt_saturate got=%h exp=000000ff", rd); end
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL evt_unarmed_ctrl got=%h exp=0", rd); end
        bus(1'b1, 5'h18, 32'h10, rd, ak);
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL evt_clear got=%h exp=0", rd); end
        @(negedge clk); lsr = 8'h62;
        @(negedge clk); lsr = 8'h60;
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL evt_single got=%h exp=1", rd); end
        // Clear write whose ack cycle coincides with a fresh OE rising edge.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h18; dat_w = 32'h10;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; lsr = 8'h62;
        @(negedge clk);
        lsr = 8'h60;
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL evt_clr_priority got=%h exp=0", rd); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); lsr = 8'h64;
            @(negedge clk); lsr = 8'h60;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lsr = 8'h70;
            @(negedge clk); lsr = 8'h60;
        end
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0300_0200) begin failures++; $display("FAIL evt_lanes got=%h exp=03000200", rd); end
    endtask

    task automatic test_trigger();
        logic [31:0] rd;
        logic ak;
        bus(1'b1, 5'h18, 32'h10, rd, ak);
        bus(1'b1, 5'h18, 32'h02, rd, ak);
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL trig_armed got=%h exp=2", rd); end
        tstate = 3'd5; lsr = 8'h68;
        @(negedge clk);
        tstate = 3'd1; lsr = 8'h60;
        checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL trig_frozen got=%b exp=1", frozen); end
        bus(1'b0, 5'h0C, 32'h0, rd, ak);
        checks++; if (rd !== 32'h00AA_0905) begin failures++; $display("FAIL trig_stat1 got=%h exp=00aa0905", rd); end
        bus(1'b0, 5'h08, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0083_0A68) begin failures++; $display("FAIL trig_stat0 got=%h exp=00830a68", rd); end
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h5) begin failures++; $display("FAIL trig_ctrl got=%h exp=5", rd); end
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL trig_fe_cnt got=%h exp=00010000", rd); end
        @(negedge clk); lsr = 8'h64;
        @(negedge clk); lsr = 8'h60;
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0001_0100) begin failures++; $display("FAIL frozen_monitor got=%h exp=00010100", rd); end
        bus(1'b0, 5'h0C, 32'h0, rd, ak);
        checks++; if (rd !== 32'h00AA_0905) begin failures++; $display("FAIL trig_still_held got=%h exp=00aa0905", rd); end
        bus(1'b1, 5'h18, 32'h0, rd, ak);
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL trig_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic ak;
        logic exp_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h14;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            exp_ack = ((i % 2) == 1);
            checks++; if (ack !== exp_ack) begin failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack, exp_ack); end
            if (exp_ack) begin
                checks++; if (dat_r !== 32'h0001_0100) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=00010100", i, dat_r); end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        bus(1'b0, 5'h1C, 32'h0, rd, ak);
        checks++; if (ak !== 1'b1) begin failures++; $display("FAIL unmapped_ack got=%b exp=1", ak); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", rd); end
        bus(1'b1, 5'h1C, 32'hFFFF_FFFF, rd, ak);
        bus(1'b1, 5'h08, 32'hFFFF_FFFF, rd, ak);
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_write got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        logic ak;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h18; dat_w = 32'h1;
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; lsr = 8'h62;
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", ack); end
        checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL midrst_lost got=%b exp=0", frozen); end
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, 5'h14, 32'h0, rd, ak);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL post_reset_edge got=%h exp=1", rd); end
        bus(1'b0, 5'h18, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl got=%h exp=0", rd); end
        bus(1'b0, 5'h10, 32'h0, rd, ak);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_wm got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_stat_read();
        test_freeze();
        test_watermark();
        test_evt_saturate();
        test_trigger();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_debug_monitor.md
# uart_debug_monitor

Parametrised debug/observation block for the UART core, successor to the flat combinational debug register mux. Exposes live or frozen snapshots of UART registers and FIFO/state-machine status over a registered Wishbone slave port, with sticky FIFO high-watermarks and saturating line-error event counters. An armable trigger freezes the snapshot on the first line error. Sits beside the UART register file on the same Wishbone bus and clock.

## Interface
- ADDR_W, 5, Wishbone address width
- CNT_W, 5, FIFO counter width (rf_count/tf_count)
- EVT_W, 8, width of each error event counter (1..8)
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, synchronous, active-low
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle/strobe/write
- wb_adr_i  in  ADDR_W  byte address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  registered read data
- wb_ack_o  out  1  single-cycle acknowledge
- ier in 4, iir in 4, fcr in 2, mcr in 5, lcr in 8, msr in 8, lsr in 8  UART register values
- rf_count, tf_count  in  CNT_W  RX/TX FIFO fill counts
- tstate in 3, rstate in 4  TX/RX state-machine states
- frozen_o  out  1  snapshot currently frozen

## Operation
- Snapshot register set (all UART inputs above) loads every cycle while freeze=0; holds while freeze=1.
- Address map (wb_adr_i compared in full):
  - 0x08 RO: {msr, lcr, iir, ier, lsr} from snapshot.
  - 0x0C RO: {8'b0, fcr, mcr, rf_count, rstate, tf_count, tstate} from snapshot; FIFO fields zero-extended/truncated to 5 bits.
  - 0x10 RO: [31:16] tf_max, [15:0] rf_max, zero-extended.
  - 0x14 RO: [31:24] bi_cnt, [23:16] fe_cnt, [15:8] pe_cnt, [7:0] oe_cnt, zero-extended from EVT_W.
  - 0x18 RW control: bit0 freeze (RW), bit1 arm (RW), bit2 triggered (RO, cleared by writing 0 to bit0), bit4 clr_evt (WO, self-clearing), bit5 clr_wm (WO, self-clearing); other bits read 0.
  - All other addresses: read 0, writes ignored.
- Watermarks: rf_max/tf_max update to live count when live > stored; unsigned compare.
- Event counters: count rising edges of live lsr[1] OE, lsr[2] PE, lsr[3] FE, lsr[4] BI against a 1-cycle delayed copy of lsr. Saturate at 2^EVT_W-1; no wrap.
- Trigger: when arm=1, freeze=0 and any of those edges occur in cycle N, the snapshot loads cycle-N values, and freeze=1, triggered=1, arm=0 from N+1.
- Priority, same cycle: clr_evt beats an event (counter=0, event lost); clr_wm beats an update (value=0). A Wishbone write to control beats the trigger.
- Monitoring (watermarks, counters, edge detect) continues while frozen.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, frozen_o=0. All snapshot, watermark, counter, control and delayed-lsr registers are 0.
  - A lsr error bit already 1 in the first cycle after reset counts as an edge.
- Access accepted when cyc&stb&!wb_ack_o.
  - wb_ack_o is high exactly 1 cycle later, with wb_dat_o valid in that cycle.
  - A held strobe yields an ack every other cycle.
- Write takes effect on the ack cycle edge: the register value is visible the cycle after ack. frozen_o reflects freeze directly.
- Read latency: 1 cycle. Read data is the register value at the acceptance edge.
- Reset asserted mid-access: ack is dropped and the access is lost.

## Structure
- Package uart_debug_pkg holds:
  - address constants DBG_STAT0=0x08, DBG_STAT1=0x0C, DBG_WM=0x10, DBG_EVT=0x14, DBG_CTRL=0x18;
  - control bit indices;
  - lsr error bit indices.
- Sub-module uart_debug_sat_cnt (EVT_W, inc, clr, count), instantiated 4 times.
- Snapshot, watermarks, control and Wishbone read path live in the top module.

## Test plan
- Reset, then read 0x08 with ier=4'hA, lsr=8'h60, lcr=8'h03 -> ack 1 cycle after stb, data=0x0003_0A60 with msr=iir=0.
- Write 0x18=1 (freeze), then change lcr to 8'h83 -> 0x08 still shows lcr=03 and frozen_o=1. Write 0 -> lcr=83 within 2 cycles.
- Ramp rf_count 0→12→3 -> 0x10 reads rf_max=12. Write 0x18 bit5 -> reads 0.
- Pulse lsr[1] 300 times with EVT_W=8 -> oe_cnt=255. Clear and pulse in the same cycle -> 0.
- Write arm, then raise lsr[3] in cycle N with tstate=5 -> snapshot tstate=5, triggered=1, arm=0, fe_cnt=1.
- Back-to-back held strobe on 0x14 -> ack pattern 0,1,0,1. Unmapped address 0x1C -> data 0.
